// File: rtl/shim_ads816x_adc_seq.sv
// ADS816x on-the-fly frame sequencer: 16-cycle n_cs-low shifts,
// a latched n_cs-high gap, and channel-tagged results one frame late.
module shim_ads816x_adc_seq #(
  parameter logic [4:0] OTF_PREFIX = 5'b10100,
  parameter int         CMD_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  n_cs_high_time,
  input  logic        timing_ready,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_channel,
  output logic        n_cs,
  output logic        sck_en,
  output logic        mosi,
  input  logic        miso,
  output logic [15:0] data,
  output logic [2:0]  data_channel,
  output logic        data_valid,
  output logic        busy,
  output logic        timing_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_READY, S_SHIFT, S_CS_HIGH
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(CMD_BITS - 1);

  state_t      state, state_nx;
  logic [7:0]  n_lat, hi_cnt;
  logic [14:0] tx, rx;
  logic [15:0] word;
  logic [3:0]  bit_cnt;
  logic [2:0]  cur_ch, prev_ch;
  logic        have_prev, accept, last_bit, abort;

  assign word     = {OTF_PREFIX, cmd_channel, 8'h00};
  assign accept   = cmd_valid & cmd_ready;
  assign last_bit = bit_cnt == LAST_BIT;
  assign abort    = (state != S_IDLE) & ~timing_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:    if (timing_ready) state_nx = S_READY;
        S_READY:   if (accept) state_nx = S_SHIFT;
        S_SHIFT:
          if (last_bit)
            state_nx = (n_lat <= 8'd1) ? S_READY : S_CS_HIGH;
        S_CS_HIGH: if (hi_cnt == 8'd0) state_nx = S_READY;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state == S_READY) & timing_ready;
    busy      = state != S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_cs         <= 1'b1;
      sck_en       <= 1'b0;
      mosi         <= 1'b0;
      data         <= '0;
      data_channel <= '0;
      data_valid   <= 1'b0;
      timing_err   <= 1'b0;
      have_prev    <= 1'b0;
      n_lat        <= '0;
      hi_cnt       <= '0;
      tx           <= '0;
      rx           <= '0;
      bit_cnt      <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
    end else begin
      data_valid <= 1'b0;
      if (abort) begin
        n_cs       <= 1'b1;
        sck_en     <= 1'b0;
        mosi       <= 1'b0;
        have_prev  <= 1'b0;
        timing_err <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE:
            if (timing_ready) begin
              n_lat     <= n_cs_high_time;
              have_prev <= 1'b0;
            end
          S_READY:
            if (accept) begin
              tx      <= word[14:0];
              cur_ch  <= cmd_channel;
              n_cs    <= 1'b0;
              sck_en  <= 1'b1;
              mosi    <= word[15];
              bit_cnt <= '0;
            end
          S_SHIFT: begin
            rx      <= {rx[13:0], miso};
            mosi    <= tx[14];
            tx      <= {tx[13:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              n_cs   <= 1'b1;
              sck_en <= 1'b0;
              mosi   <= 1'b0;
              // result shifted in now belongs to the previous command
              if (have_prev) begin
                data         <= {rx, miso};
                data_channel <= prev_ch;
                data_valid   <= 1'b1;
              end
              prev_ch   <= cur_ch;
              have_prev <= 1'b1;
              hi_cnt    <= n_lat - 8'd2;
            end
          end
          S_CS_HIGH: hi_cnt <= hi_cnt - 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shim_ads816x_adc_seq.sv
// Frame-level bench: ADC responder plus a queue model of the
// one-frame-late OTF result pipeline.
module tb_shim_ads816x_adc_seq;

  localparam logic [4:0] PREFIX = 5'b10100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  n_cs_high_time = '0;
  logic        timing_ready = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_channel = '0;
  logic        n_cs, sck_en, mosi;
  logic        miso = 1'b0;
  logic [15:0] data;
  logic [2:0]  data_channel;
  logic        data_valid, busy, timing_err;

  int n_chk = 0;
  int n_fail = 0;

  int          ch_q[$];
  int          gap_q[$];
  logic [18:0] dq[$];
  logic [15:0] miso_q[$];

  bit          m_have = 0;
  bit          cut_pend = 0;
  bit          in_frame = 0;
  int          m_prev = 0;
  int          cur_ch = 0;
  int          lo_len = 0;
  int          hi_len = 0;
  int          sck_cnt = 0;
  int          dv_cnt = 0;
  logic [15:0] mosi_w = '0;
  logic [15:0] cur_word = '0;
  logic [15:0] exp_w;
  logic [18:0] e;

  shim_ads816x_adc_seq dut (
    .clk(clk),
    .rst(rst),
    .n_cs_high_time(n_cs_high_time),
    .timing_ready(timing_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel),
    .n_cs(n_cs),
    .sck_en(sck_en),
    .mosi(mosi),
    .miso(miso),
    .data(data),
    .data_channel(data_channel),
    .data_valid(data_valid),
    .busy(busy),
    .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ADC responder and frame monitor, all at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      lo_len = 0;
      hi_len = 0;
      miso = 1'b0;
    end else begin
      if (n_cs === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1;
          lo_len = 0;
          sck_cnt = 0;
          mosi_w = '0;
          if (ch_q.size() == 0) begin
            check("unexp_frame", 1, 0);
            cur_ch = 0;
          end else begin
            cur_ch = ch_q.pop_front();
            if (gap_q[0] >= 0) check("ncs_gap", hi_len, gap_q[0]);
            void'(gap_q.pop_front());
          end
          cur_word = (miso_q.size() != 0) ? miso_q.pop_front()
                                          : 16'($urandom);
        end
        if (lo_len < 16) miso = cur_word[4'(15 - lo_len)];
        mosi_w = {mosi_w[14:0], mosi};
        sck_cnt += int'(sck_en);
        lo_len++;
      end else begin
        if (in_frame) begin
          in_frame = 0;
          hi_len = 0;
          if (cut_pend) begin
            cut_pend = 0;
            m_have = 0;
          end else begin
            exp_w = {PREFIX, 3'(cur_ch), 8'h00};
            check("lo_len", lo_len, 16);
            check("sck_cnt", sck_cnt, 16);
            check("mosi_word", mosi_w, exp_w);
            check("dv_at_end", data_valid, m_have);
            if (m_have) dq.push_back({cur_word, 3'(m_prev)});
            m_prev = cur_ch;
            m_have = 1;
          end
        end
        check("sck_hi", sck_en, 0);
        check("mosi_hi", mosi, 0);
        hi_len++;
        miso = 1'b0;
      end
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (dq.size() == 0) begin
          check("unexp_dv", 1, 0);
        end else begin
          e = dq.pop_front();
          check("data", data, e[18:3]);
          check("data_ch", data_channel, e[2:0]);
        end
      end
    end
  end

  task automatic reset_checks();
    check("rst_ncs", n_cs, 1);
    check("rst_sck", sck_en, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rdy", cmd_ready, 0);
    check("rst_data", data, 0);
    check("rst_dch", data_channel, 0);
    check("rst_dv", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timing_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    timing_ready = 1'b0;
    cmd_valid = 1'b0;
    ch_q.delete();
    gap_q.delete();
    dq.delete();
    miso_q.delete();
    cut_pend = 0;
    m_have = 0;
    @(negedge clk);
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run(input int n);
    n_cs_high_time = 8'(n);
    m_have = 0;
    timing_ready = 1'b1;
  endtask

  task automatic send(input int ch, input int gap);
    int t;
    t = 0;
    cmd_channel = 3'(ch);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      check("accept_timeout", 0, 1);
    end else begin
      ch_q.push_back(ch);
      gap_q.push_back(gap);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0, g, t;
    int nlist[5];

    do_reset();

    miso_q = '{16'h5A5A, 16'h1234, 16'hBEEF};
    start_run(3);
    d0 = dv_cnt;
    send(2, -1);
    send(5, 3);
    send(7, 3);
    settle(30);
    check("s1_dv", dv_cnt - d0, 2);
    check("s1_left", dq.size(), 0);

    nlist = '{0, 1, 255, 2, 7};
    nlist[3] = int'($urandom_range(2, 40));
    foreach (nlist[i]) begin
      do_reset();
      start_run(nlist[i]);
      d0 = dv_cnt;
      g = (nlist[i] < 1) ? 1 : nlist[i];
      send(int'($urandom_range(0, 7)), -1);
      repeat (3) send(int'($urandom_range(0, 7)), g);
      settle(g + 30);
      check("s2_dv", dv_cnt - d0, 3);
      check("s2_left", dq.size(), 0);
    end

    do_reset();
    start_run(3);
    d0 = dv_cnt;
    send(int'($urandom_range(0, 7)), -1);
    t = 0;
    while (n_cs !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("s3_timeout", 0, 1);
    settle(12);
    send(int'($urandom_range(0, 7)), 13);
    send(int'($urandom_range(0, 7)), 3);
    settle(30);
    check("s3_dv", dv_cnt - d0, 2);

    do_reset();
    start_run(3);
    d0 = dv_cnt;
    send(1, -1);
    n_cs_high_time = 8'd20;
    send(4, 3);
    send(6, 3);
    settle(30);
    timing_ready = 1'b0;
    settle(2);
    check("s4_busy", busy, 0);
    start_run(20);
    send(3, -1);
    send(0, 20);
    settle(40);
    check("s4_dv", dv_cnt - d0, 3);

    do_reset();
    start_run(3);
    d0 = dv_cnt;
    send(int'($urandom_range(0, 7)), -1);
    send(int'($urandom_range(0, 7)), 3);
    settle(8);
    cut_pend = 1;
    timing_ready = 1'b0;
    @(negedge clk);
    check("s5_ncs", n_cs, 1);
    check("s5_busy", busy, 0);
    check("s5_terr", timing_err, 1);
    check("s5_sck", sck_en, 0);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s5_nordy", cmd_ready, 0);
      check("s5_idle_ncs", n_cs, 1);
    end
    cmd_valid = 1'b0;
    check("s5_dv", dv_cnt - d0, 0);
    start_run(3);
    send(int'($urandom_range(0, 7)), -1);
    send(int'($urandom_range(0, 7)), 3);
    settle(30);
    check("s5_sticky", timing_err, 1);
    check("s5_dv2", dv_cnt - d0, 1);

    do_reset();
    start_run(3);
    send(int'($urandom_range(0, 7)), -1);
    settle(5);
    #2;
    rst = 1'b1;
    #1;
    check("s6_ncs", n_cs, 1);
    check("s6_sck", sck_en, 0);
    check("s6_busy", busy, 0);
    check("s6_mosi", mosi, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
